// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: pipeline/CP0 bundle between the MEM stage and the exception controller.
interface cp0_exc_ctrl_if;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic        eret_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        mtc0_we_i;
  logic [4:0]  mtc0_addr_i;
  logic [31:0] mtc0_data_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        cause_upd_o;
  logic [4:0]  cause_code_o;
  logic        cause_bd_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  modport master (
    output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, eret_i, status_i, cause_i, epc_i,
           mtc0_we_i, mtc0_addr_i, mtc0_data_i,
    input  cp0_we_o, cp0_waddr_o, cp0_wdata_o, cause_upd_o, cause_code_o, cause_bd_o,
           stall_o, flush_o, new_pc_o, busy_o
  );
  modport slave (
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, eret_i, status_i, cause_i, epc_i,
           mtc0_we_i, mtc0_addr_i, mtc0_data_i,
    output cp0_we_o, cp0_waddr_o, cp0_wdata_o, cause_upd_o, cause_code_o, cause_bd_o,
           stall_o, flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: sequences CP0 EPC/Cause/Status updates and the PC redirect for exceptions, interrupts and ERET.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input logic            clk,
  input logic            rst,
  cp0_exc_ctrl_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_EPC    = 3'd1;
  localparam logic [2:0] W_CAUSE  = 3'd2;
  localparam logic [2:0] W_STATUS = 3'd3;
  localparam logic [2:0] E_STATUS = 3'd4;
  localparam logic [2:0] REDIRECT = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d, status_q, status_d;
  logic        bd_q, bd_d, eret_q, eret_d;
  logic        idle, irq, take_exc, take_eret, pass, w_st;
  always_comb begin
    idle      = state_q == IDLE;
    irq       = |(bus.cause_i[15:8] & bus.status_i[15:8]) && bus.status_i[0] && !bus.status_i[1];
    take_exc  = idle && (irq || bus.exc_valid_i);
    take_eret = idle && !take_exc && bus.eret_i;
    pass      = idle && !take_exc && !take_eret && bus.mtc0_we_i;
    w_st      = state_q == W_STATUS || state_q == E_STATUS;
    state_d   = take_exc ? W_EPC : take_eret ? E_STATUS :
                state_q == W_EPC ? W_CAUSE : state_q == W_CAUSE ? W_STATUS :
                w_st ? REDIRECT : IDLE;
    // an interrupt overrides any coincident exception code but keeps its PC/BD
    code_d    = take_exc ? (irq ? 5'd0 : bus.exc_code_i) : code_q;
    pc_d      = take_exc ? bus.exc_pc_i : take_eret ? bus.epc_i : pc_q;
    bd_d      = take_exc ? bus.exc_bd_i : take_eret ? 1'b0 : bd_q;
    status_d  = (take_exc || take_eret) ? bus.status_i : status_q;
    eret_d    = take_exc ? 1'b0 : take_eret ? 1'b1 : eret_q;
    bus.cp0_we_o     = state_q == W_EPC || w_st || pass;
    bus.cp0_waddr_o  = state_q == W_EPC ? 5'd14 : w_st ? 5'd12 : pass ? bus.mtc0_addr_i : 5'd0;
    bus.cp0_wdata_o  = state_q == W_EPC ? (bd_q ? pc_q - 32'd4 : pc_q) :
                       state_q == W_STATUS ? (status_q | 32'h2) :
                       state_q == E_STATUS ? (status_q & ~32'h2) :
                       pass ? bus.mtc0_data_i : 32'd0;
    bus.cause_upd_o  = state_q == W_CAUSE;
    bus.cause_code_o = state_q == W_CAUSE ? code_q : 5'd0;
    bus.cause_bd_o   = state_q == W_CAUSE && bd_q;
    bus.flush_o      = state_q == REDIRECT;
    bus.new_pc_o     = state_q == REDIRECT ? (eret_q ? pc_q : EXC_VECTOR) : 32'd0;
    bus.busy_o       = !idle;
    bus.stall_o      = !idle || take_exc || take_eret;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      pc_q     <= '0;
      status_q <= '0;
      bd_q     <= 1'b0;
      eret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      status_q <= status_d;
      bd_q     <= bd_d;
      eret_q   <= eret_d;
    end
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: per-cycle vector table; expected outputs are queued at drive time and checked mid-cycle.
module tb_cp0_exc_ctrl;
  typedef struct packed {
    logic rst; logic ev; logic [4:0] code; logic [31:0] pc; logic bd; logic er;
    logic [31:0] st; logic [31:0] ca; logic [31:0] epc; logic mw; logic [4:0] ma; logic [31:0] md;
  } in_t;
  typedef struct packed {
    logic we; logic [4:0] wa; logic [31:0] wd; logic cu; logic [4:0] cc; logic cb;
    logic stl; logic fl; logic [31:0] np; logic bz;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cp0_exc_ctrl_if bus ();
  cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  vec_t vq[$];
  out_t sb[$];
  int applied = 0;
  int errors  = 0;
  function automatic in_t mi(logic r, logic ev, logic [4:0] code, logic [31:0] pc, logic bd, logic er,
                             logic [31:0] st, logic [31:0] ca, logic [31:0] epc, logic mw,
                             logic [4:0] ma, logic [31:0] md);
    return '{r, ev, code, pc, bd, er, st, ca, epc, mw, ma, md};
  endfunction
  function automatic out_t mo(logic we, logic [4:0] wa, logic [31:0] wd, logic cu, logic [4:0] cc,
                              logic cb, logic stl, logic fl, logic [31:0] np, logic bz);
    return '{we, wa, wd, cu, cc, cb, stl, fl, np, bz};
  endfunction
  task automatic add(input in_t i, input out_t o);
    vq.push_back('{i, o});
  endtask
  task automatic drive(input in_t i);
    rst = i.rst;
    bus.exc_valid_i = i.ev;  bus.exc_code_i = i.code; bus.exc_pc_i = i.pc; bus.exc_bd_i = i.bd;
    bus.eret_i = i.er;       bus.status_i = i.st;     bus.cause_i = i.ca;  bus.epc_i = i.epc;
    bus.mtc0_we_i = i.mw;    bus.mtc0_addr_i = i.ma;  bus.mtc0_data_i = i.md;
  endtask
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: vector run did not finish");
    $finish;
  end
  initial begin
    in_t  n;
    out_t z, got, exp;
    n   = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z   = '0;
    add(n, z);
    add(mi(0, 1, 8, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(n, mo(1, 14, 32'h400, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 1, 8, 0, 1, 0, 0, 1));
    add(n, mo(1, 12, 32'h2, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1));
    add(n, z);
    add(mi(0, 1, 4, 32'h0, 1, 0, 32'h10, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(n, mo(1, 14, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 1, 4, 1, 1, 0, 0, 1));
    add(n, mo(1, 12, 32'h12, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1));
    add(mi(0, 1, 12, 32'h800, 0, 0, 32'hFF01, 32'h400, 0, 1, 11, 5), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(n, mo(1, 14, 32'h800, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    add(n, mo(1, 12, 32'hFF03, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1));
    add(mi(0, 0, 0, 0, 0, 1, 3, 0, 32'h1234, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(mi(0, 1, 9, 32'h40, 0, 1, 0, 0, 0, 1, 11, 5), mo(1, 12, 32'h1, 0, 0, 0, 1, 0, 0, 1));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 5), mo(0, 0, 0, 0, 0, 0, 1, 1, 32'h1234, 1));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 5), mo(1, 11, 5, 0, 0, 0, 0, 0, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 32'hFF03, 32'h400, 0, 1, 7, 32'hABCD), mo(1, 7, 32'hABCD, 0, 0, 0, 0, 0, 0, 0));
    add(mi(0, 0, 0, 0, 0, 1, 32'hFF00, 32'h400, 32'h88, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(n, mo(1, 12, 32'hFF00, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 0, 0, 0, 1, 1, 32'h88, 1));
    add(mi(0, 1, 5, 32'h100, 0, 1, 0, 0, 32'h999, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(n, mo(1, 14, 32'h100, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 1, 5, 0, 1, 0, 0, 1));
    add(n, mo(1, 12, 32'h2, 0, 0, 0, 1, 0, 0, 1));
    add(n, mo(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1));
    add(mi(0, 1, 8, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(n, mo(1, 14, 32'h400, 0, 0, 0, 1, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 8, 0, 1, 0, 0, 1));
    add(n, z);
    add(n, z);
    add(n, z);
    drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = '{bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_wdata_o, bus.cause_upd_o, bus.cause_code_o,
            bus.cause_bd_o, bus.stall_o, bus.flush_o, bus.new_pc_o, bus.busy_o};
    applied++;
    if (got !== z) begin
      errors++;
      $display("FAIL reset state: outputs %h not all zero", got);
    end
    foreach (vq[k]) begin
      @(posedge clk);
      #1;
      drive(vq[k].i);
      sb.push_back(vq[k].o);
      @(negedge clk);
      got = '{bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_wdata_o, bus.cause_upd_o, bus.cause_code_o,
              bus.cause_bd_o, bus.stall_o, bus.flush_o, bus.new_pc_o, bus.busy_o};
      exp = sb.pop_front();
      applied++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got we=%b wa=%0d wd=%h cu=%b cc=%0d cb=%b stall=%b flush=%b npc=%h busy=%b | want we=%b wa=%0d wd=%h cu=%b cc=%0d cb=%b stall=%b flush=%b npc=%h busy=%b",
                 k, got.we, got.wa, got.wd, got.cu, got.cc, got.cb, got.stl, got.fl, got.np, got.bz,
                 exp.we, exp.wa, exp.wd, exp.cu, exp.cc, exp.cb, exp.stl, exp.fl, exp.np, exp.bz);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
